// File: rtl/writeback_queue.sv
// Writeback queue: merges MEM and ALU results into a DEPTH-entry circular FIFO that
// drains one register-file write per cycle and forwards pending values to decode.
module writeback_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_valid,
    input  logic [4:0]               mem_rd,
    input  logic [31:0]              mem_data,
    output logic                     mem_ready,
    input  logic                     alu_valid,
    input  logic [4:0]               alu_rd,
    input  logic [31:0]              alu_data,
    output logic                     alu_ready,
    output logic                     RegWrite,
    output logic [4:0]               rd,
    output logic [31:0]              Data_In,
    input  logic [4:0]               rs,
    input  logic [4:0]               rt,
    output logic                     fwd_rs_hit,
    output logic                     fwd_rt_hit,
    output logic [31:0]              fwd_rs_data,
    output logic [31:0]              fwd_rt_data,
    output logic                     stall,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;
    logic [CntW-1:0] space;
    logic [4:0]      ent_rd_q   [DEPTH];
    logic [31:0]     ent_data_q [DEPTH];
    logic            mem_fire, alu_fire, pop;
    logic [PtrW-1:0] alu_waddr;

    // Space comes from registered state only; the pop happening this cycle is not credited.
    assign space     = CntW'(DEPTH) - count_q;
    assign mem_ready = (space != '0);
    assign alu_ready = mem_valid ? (space >= CntW'(2)) : (space != '0);
    assign stall     = (alu_valid & ~alu_ready) | (mem_valid & ~mem_ready);

    assign mem_fire  = mem_valid & mem_ready & ~rst;
    assign alu_fire  = alu_valid & alu_ready & ~rst;
    assign pop       = (count_q != '0);
    // The older MEM result takes the tail slot first when both paths transfer.
    assign alu_waddr = tail_q + PtrW'(mem_fire);

    assign RegWrite  = pop;
    assign rd        = pop ? ent_rd_q[head_q]   : 5'd0;
    assign Data_In   = pop ? ent_data_q[head_q] : 32'd0;
    assign count     = count_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (rst) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PtrW'(pop);
            tail_d  = tail_q + PtrW'(mem_fire) + PtrW'(alu_fire);
            count_d = count_q + CntW'(mem_fire) + CntW'(alu_fire) - CntW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        head_q  <= head_d;
        tail_q  <= tail_d;
        count_q <= count_d;
    end

    always_ff @(posedge clk) begin
        if (mem_fire) begin
            ent_rd_q[tail_q]   <= mem_rd;
            ent_data_q[tail_q] <= mem_data;
        end
        if (alu_fire) begin
            ent_rd_q[alu_waddr]   <= alu_rd;
            ent_data_q[alu_waddr] <= alu_data;
        end
    end

    // Walk oldest to youngest so the last match seen is the youngest producer.
    always_comb begin
        logic [PtrW-1:0] idx;
        fwd_rs_hit  = 1'b0;
        fwd_rt_hit  = 1'b0;
        fwd_rs_data = 32'd0;
        fwd_rt_data = 32'd0;
        idx         = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head_q + PtrW'(i);
            if (CntW'(i) < count_q) begin
                if (ent_rd_q[idx] == rs) begin
                    fwd_rs_hit  = 1'b1;
                    fwd_rs_data = ent_data_q[idx];
                end
                if (ent_rd_q[idx] == rt) begin
                    fwd_rt_hit  = 1'b1;
                    fwd_rt_data = ent_data_q[idx];
                end
            end
        end
    end

endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 Parameter DEPTH, default 4, gives the number of pending-write entries; it SHALL be a power of two and at least 2.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1 bit: the reset; it SHALL be synchronous and active-high.
REQ-004 Port mem_valid, input, 1 bit: the MEM-stage (load) result is present.
REQ-005 Port mem_rd / mem_data, input, 5 / 32 bits: the MEM-stage destination register and its data.
REQ-006 Port mem_ready, output, 1 bit: the MEM-stage result is accepted this cycle.
REQ-007 Port alu_valid, input, 1 bit: the EX-stage (ALU) result is present.
REQ-008 Port alu_rd / alu_data, input, 5 / 32 bits: the EX-stage destination register and its data.
REQ-009 Port alu_ready, output, 1 bit: the EX-stage result is accepted this cycle.
REQ-010 Port RegWrite, output, 1 bit: the register-file write enable.
REQ-011 Port rd / Data_In, output, 5 / 32 bits: the register-file write address and write data.
REQ-012 Port rs / rt, input, 5 bits each: the decode-stage source register numbers used for lookup.
REQ-013 Port fwd_rs_hit / fwd_rt_hit, output, 1 bit each: a pending entry targets rs / rt.
REQ-014 Port fwd_rs_data / fwd_rt_data, output, 32 bits each: the forwarded value for rs / rt.
REQ-015 Port stall, output, 1 bit: a valid producer was refused this cycle.
REQ-016 Port count, output, clog2(DEPTH)+1 bits: the number of occupied entries.

Function
REQ-017 Storage SHALL be a circular FIFO of DEPTH entries, each holding {rd[4:0], data[31:0]}, with head and tail pointers that wrap modulo DEPTH.
REQ-018 space = DEPTH - count, evaluated from registered state; a same-cycle pop SHALL NOT be credited.
REQ-019 mem_ready SHALL be (space >= 1).
REQ-020 alu_ready SHALL be (space >= 2) when mem_valid=1, and (space >= 1) otherwise.
REQ-021 A transfer on a path SHALL occur when that path's valid and ready are both 1.
REQ-022 When both paths transfer in the same cycle, the MEM entry (the older instruction) SHALL be enqueued before the ALU entry.
REQ-023 RegWrite SHALL be (count != 0); rd and Data_In SHALL be combinational from the head entry, and SHALL be 0 when the FIFO is empty.
REQ-024 A pop SHALL occur on every edge where RegWrite=1, with exactly one write per cycle.
REQ-025 Latency: an entry enqueued at edge N into an empty FIFO SHALL drive RegWrite/rd/Data_In during cycle N+1 and SHALL be popped at edge N+1.
REQ-026 count(next) SHALL be count + enqueues - pop, where enqueues is 0 to 2 and pop is 0 or 1; overflow and underflow SHALL be impossible by construction.
REQ-027 rd=0 entries SHALL be queued and written like any other register, with no suppression.
REQ-028 fwd_rs_hit SHALL be 1 when any occupied entry, including the head being popped this cycle, has rd==rs.
REQ-029 fwd_rs_data SHALL be the data of the youngest matching entry, or 0 when there is no hit.
REQ-030 fwd_rt_hit and fwd_rt_data SHALL follow the same rules as REQ-028 and REQ-029, applied to rt.
REQ-031 Entries arriving in the current cycle SHALL NOT be visible to forwarding until the following cycle.
REQ-032 stall SHALL be (alu_valid & ~alu_ready) | (mem_valid & ~mem_ready).
REQ-033 Input data SHALL be captured only on a transfer; inputs are don't-care when the corresponding valid=0.

Reset
REQ-034 While rst=1 at an edge, head, tail and count SHALL be set to 0 and all pending entries SHALL be discarded, including during active operation.
REQ-035 In the cycle after a reset edge, RegWrite, rd, Data_In, both fwd hits, both fwd data, and stall SHALL be 0.
REQ-036 In the cycle after a reset edge, mem_ready SHALL be 1, and alu_ready SHALL be 1.
REQ-037 Entry payload storage SHALL NOT require reset.
REQ-038 A transfer presented during a reset cycle SHALL be dropped.

Verification
REQ-039 Reset, then alu_valid=1, alu_rd=5, alu_data=0x1234 for one cycle -> next cycle RegWrite=1, rd=5, Data_In=0x1234, count=1; the following cycle RegWrite=0, count=0.
REQ-040 Empty FIFO, mem_valid=1 (rd=3, data=0xA) and alu_valid=1 (rd=3, data=0xB) in the same cycle -> both accepted; writes occur in the order 0xA then 0xB.
REQ-041 In the cycle after the REQ-040 transfer, rs=3 -> fwd_rs_hit=1 and fwd_rs_data=0xB.
REQ-042 DEPTH=4, both valid held every cycle -> count goes 0, 2, 3, then holds at 3, with alu_ready=0 and stall=1 from the third cycle onward.
REQ-043 Six back-to-back single ALU writes with rd=1..6 and data=0x11..0x66 -> six writes in order, pointers wrap with no loss, and count ends at 0.
REQ-044 With count=3, assert rst for one cycle -> count=0, RegWrite=0, fwd_rs_hit=0 and fwd_rt_hit=0 for any rs/rt, and no queued write emerges afterwards.
